// File: rtl/eth_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_port_arb_if
// Brief    : Requester-side and egress-side signal bundle for eth_port_arb.
// Revision : 1.0
// ============================================================================
interface eth_port_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    in_vld;
    logic [34*NUM_REQ-1:0] in_word;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    acc;
    logic                  out_stall;
    logic                  out_vld;
    logic [33:0]           out_word;

    modport slave (
        input  req, in_vld, in_word, out_stall,
        output gnt, acc, out_vld, out_word
    );

    modport master (
        output req, in_vld, in_word, out_stall,
        input  gnt, acc, out_vld, out_word
    );
endinterface
`default_nettype wire

// File: rtl/eth_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_port_arb
// Brief    : Packet-level round-robin arbiter and output mux for one egress port.
// Revision : 1.0
// ============================================================================
module eth_port_arb #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    eth_port_arb_if.slave    bus,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int C_IDX_W  = $clog2(NUM_REQ);
    localparam int C_BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int C_WORD_W = 34;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                r_state;
    logic [C_IDX_W-1:0]    r_owner;
    logic [C_IDX_W-1:0]    r_rr_ptr;
    logic [C_BEAT_W-1:0]   r_beat_cnt;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_out_vld;
    logic [C_WORD_W-1:0]   r_out_word;
    logic                  r_timeout_err;
    logic [CNT_W-1:0]      r_pkt_cnt;

    logic [C_IDX_W:0]      w_cand;
    logic [C_IDX_W-1:0]    w_win;
    logic                  w_any;
    logic [NUM_REQ-1:0]    w_win_onehot;
    logic [C_WORD_W-1:0]   w_own_word;
    logic [NUM_REQ-1:0]    w_acc;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_force;
    logic                  w_release;
    logic [C_IDX_W-1:0]    w_next_ptr;

    // Scan from rr_ptr upward with wraparound; the first requester hit wins.
    always_comb begin
        w_cand = '0;
        w_win  = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (C_IDX_W+1)'(k);
            if (w_cand >= (C_IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (C_IDX_W+1)'(NUM_REQ);
            end
            if (!w_any && bus.req[w_cand[C_IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[C_IDX_W-1:0];
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win;

    always_comb begin
        w_own_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == C_IDX_W'(i)) begin
                w_own_word = bus.in_word[C_WORD_W*i +: C_WORD_W];
            end
        end
    end

    // gnt is zero outside LOCK, so any accept belongs to the current owner.
    assign w_acc      = r_gnt & bus.in_vld & {NUM_REQ{~bus.out_stall}};
    assign w_accept   = |w_acc;
    assign w_last     = (r_beat_cnt == C_BEAT_W'(MAX_BEATS - 1));
    assign w_force    = w_accept & ~w_own_word[33] & w_last;
    assign w_release  = w_accept & (w_own_word[33] | w_last);
    assign w_next_ptr = (r_owner == C_IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + C_IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_gnt         <= '0;
            r_out_vld     <= 1'b0;
            r_out_word    <= '0;
            r_timeout_err <= 1'b0;
            r_pkt_cnt     <= '0;
        end else begin
            r_out_vld     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_win_onehot;
                        r_owner    <= w_win;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_accept) begin
                        r_out_vld  <= 1'b1;
                        r_out_word <= {w_own_word[33] | w_force, w_own_word[32:0]};
                        r_beat_cnt <= r_beat_cnt + C_BEAT_W'(1);
                        if (w_release) begin
                            r_gnt         <= '0;
                            r_rr_ptr      <= w_next_ptr;
                            r_pkt_cnt     <= r_pkt_cnt + CNT_W'(1);
                            r_timeout_err <= w_force;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.acc      = w_acc;
    assign bus.out_vld  = r_out_vld;
    assign bus.out_word = r_out_word;
    assign busy         = (r_state == ST_LOCK);
    assign timeout_err  = r_timeout_err;
    assign pkt_cnt      = r_pkt_cnt;

endmodule
`default_nettype wire

// File: doc/eth_port_arb.md
# eth_port_arb

Packet-level round-robin arbiter and output mux for one egress port of the Ethernet switch. It sits between the per-input-port FIFOs, which hold 34-bit words {eop,sop,data[31:0]}, and one switch output port. Requesters whose head-of-line packet targets this port compete for it. The winner owns the port until its EOP beat is accepted, or until a maximum-length timeout forcibly closes the packet.

## Interface
- NUM_REQ, 2, number of requesters (input queues), must be ≥2
- MAX_BEATS, 64, maximum accepted beats per packet before forced termination
- CNT_W, 16, width of the packet counter

- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  req[i]=1: queue i has a packet head destined to this port
- in_vld  in  NUM_REQ  queue i presents a beat this cycle
- in_word  in  34*NUM_REQ  beat from queue i, in bits [34*i+33:34*i]; bit 33 eop, bit 32 sop, [31:0] data
- out_stall  in  1  downstream cannot accept; no beat is consumed this cycle
- gnt  out  NUM_REQ  registered one-hot grant, all zero when idle
- acc  out  NUM_REQ  combinational: acc[i] = gnt[i] & in_vld[i] & ~out_stall; queue i pops on acc[i]
- out_vld  out  1  registered output beat valid
- out_word  out  34  registered output beat {eop,sop,data}
- busy  out  1  port locked to a requester (state LOCK)
- timeout_err  out  1  one-cycle pulse when a packet is force-terminated
- pkt_cnt  out  CNT_W  count of packets completed (EOP or forced), wraps

## Operation
- States: IDLE, LOCK.
- IDLE: if |req, the winner is the first i with req[i]=1, scanning from rr_ptr upward modulo NUM_REQ. Next cycle: gnt = onehot(winner), owner = winner, beat_cnt = 0, state LOCK. If req = 0, stay IDLE.
- LOCK: req is ignored. Each cycle with acc[owner]=1 is an accepted beat: out_word <= in_word[owner], out_vld <= 1, beat_cnt++.
- Release on an accepted beat with eop=1 → next cycle gnt=0, rr_ptr = (owner+1) mod NUM_REQ, pkt_cnt++, state IDLE.
- Timeout: an accepted beat with eop=0 while beat_cnt = MAX_BEATS-1 is output with eop forced to 1. The block then pulses timeout_err for one cycle and releases exactly as for EOP (pkt_cnt++, rr_ptr advance).
- Cycles with no accepted beat: out_vld <= 0. out_word holds its last value.
- in_vld and in_word from non-granted requesters are ignored. Their acc stays 0.
- sop is passed through unchecked.
- Round-robin fairness: a continuously requesting queue waits at most NUM_REQ-1 packets.

## Timing
- Reset (async, immediate) values: state IDLE, gnt 0, rr_ptr 0, beat_cnt 0, out_vld 0, out_word 0, timeout_err 0, pkt_cnt 0, busy 0.
- Reset mid-packet: the packet is abandoned. No EOP is emitted and no count or error is recorded.
- Arbitration latency: req sampled in cycle T → gnt asserted in T+1. The first acc is possible in T+1.
- Data latency: beat accepted in cycle T → out_vld/out_word valid in T+1.
- acc is combinational from gnt, in_vld and out_stall, all in the same cycle.
- The EOP beat is accepted in T, so gnt=0 in T+1 (IDLE, arbitrating) and the next gnt comes in T+2. Minimum inter-packet gap is one idle cycle on acc.
- out_stall=1 in the EOP cycle: the beat is not accepted and the lock is kept until it is.
- out_stall cycles do not advance beat_cnt.
- Simultaneous req from all queues with rr_ptr=0: queue 0 wins. The next contention is won by queue 1.
- pkt_cnt wraps from 2^CNT_W-1 to 0.

## Test plan
- Single packet: req=01, queue 0 sends 4 beats (sop on beat 0, eop on beat 3), no stall → gnt=01 one cycle after req; out_vld high for 4 cycles, each beat matching its input one cycle later; gnt=00 after EOP; pkt_cnt=1; rr_ptr=1.
- Contention: req=11 held, each queue sends a 3-beat packet → grant order 0,1,0,1; one idle acc cycle between packets; no interleaving of words on out_word.
- Stall: out_stall=1 for 2 cycles mid-packet → acc=0 and out_vld=0 for those cycles; beats are neither lost nor duplicated; EOP is still delivered and released.
- Timeout: MAX_BEATS=8, queue 1 sends 10 beats with no eop → the 8th beat comes out with eop=1; timeout_err pulses once; gnt drops; pkt_cnt increments; queue 1 is not granted again while queue 0 is requesting.
- Reset mid-packet: assert reset during beat 2 of 5 → gnt, out_vld, busy and pkt_cnt are 0 immediately. After deassertion, req=10 → queue 1 granted (rr_ptr is 0; queue 0 not requesting).
